// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment display driver.
// A shadow register holds NUM_DIGITS BCD/hex nibbles, captured on load.
// A prescaler holds each digit active for SCAN_DIV clocks. The driver
// registers a one-hot digit enable and that digit's segment pattern, and
// pulses frame_tick when the scan wraps back to digit 0.
// Optional feature: define SEG7_LZB_EN to blank leading zero digits.
`timescale 1ns/1ps

// Per-digit decoder: nibble -> segment pattern, with error and blank overrides.
// Bit order is {dp(0), a, b, c, d, e, f, g}.
module seg7_digit_dec #(
  parameter int NUM_DIGITS = 4,
  parameter int POS        = 0
) (
  input  logic [3:0] nib_i,
  input  logic       err_i,
  input  logic       blank_i,
  output logic [7:0] pat_o
);

  // The error message "Err" occupies the top three digit positions, and it
  // overrides the nibble value and the blanking mask.
  always_comb begin
    pat_o = 8'h00;
    if (err_i) begin
      if (POS == NUM_DIGITS-1)
        pat_o = 8'h4F;
      else if ((POS == NUM_DIGITS-2) || (POS == NUM_DIGITS-3))
        pat_o = 8'h05;
    end else if (!blank_i) begin
      case (nib_i)
        4'h0:    pat_o = 8'h7E;
        4'h1:    pat_o = 8'h30;
        4'h2:    pat_o = 8'h6D;
        4'h3:    pat_o = 8'h79;
        4'h4:    pat_o = 8'h33;
        4'h5:    pat_o = 8'h5B;
        4'h6:    pat_o = 8'h5F;
        4'h7:    pat_o = 8'h70;
        4'h8:    pat_o = 8'h7F;
        4'h9:    pat_o = 8'h7B;
        4'hA:    pat_o = 8'h4F;  // 'E'
        4'hB:    pat_o = 8'h05;  // 'r'
        default: pat_o = 8'h00;  // C..F shown blank
      endcase
    end
  end

endmodule

module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    error,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0]         PRESC_LAST = PW'(SCAN_DIV-1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS-1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);

  logic [PW-1:0]                 presc_q, presc_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]    shadow_q, shadow_d;
  logic                          err_q, err_d;
  logic [7:0]                    seg_q, seg_d;
  logic [NUM_DIGITS-1:0]         sel_q, sel_d;
  logic                          ft_q, ft_d;

  logic                          slot_end;
  logic [NUM_DIGITS-1:0]         blank;
  logic [NUM_DIGITS-1:0][7:0]    pat;

`ifdef SEG7_LZB_EN
  // Leading-zero mask: a digit is blanked while every digit from the top down
  // to it is zero. Digit 0 is never blanked so that a value of 0 still shows.
  always_comb begin
    logic run;
    blank = '0;
    run   = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 1; i--) begin
      run      = run & (shadow_q[i] == 4'h0);
      blank[i] = run;
    end
  end
`else
  assign blank = '0;
`endif

  // One decoder per digit position; the scan index selects among them.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_digit_dec #(
      .NUM_DIGITS (NUM_DIGITS),
      .POS        (g)
    ) u_dec (
      .nib_i   (shadow_q[g]),
      .err_i   (err_q),
      .blank_i (blank[g]),
      .pat_o   (pat[g])
    );
  end

  // Next-state: prescaler, scan index, shadow capture and registered outputs.
  // Outputs follow the index by one clock; frame_tick rides along with the
  // digit_sel transition from the top digit back to digit 0.
  always_comb begin
    slot_end = (presc_q == PRESC_LAST);
    presc_d  = slot_end ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    if (slot_end)
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    shadow_d = load ? bcd_in : shadow_q;
    err_d    = load ? error  : err_q;
    sel_d    = SEL_ONE << idx_q;
    seg_d    = pat[idx_q];
    ft_d     = sel_q[NUM_DIGITS-1] & (idx_q == '0);
  end

  // State update; reset wins over load and restarts the scan from digit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
      seg_q    <= 8'h00;
      sel_q    <= '0;
      ft_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      ft_q     <= ft_d;
    end
  end

  assign seg        = seg_q;
  assign digit_sel  = sel_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4.
// Expected frames are queued as stimulus is applied; a monitor aligns to
// frame_tick and compares one queued entry per cycle.
`timescale 1ns/1ps

module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset, load, error;
  logic [4*ND-1:0] bcd_in;
  logic [7:0]    seg;
  logic [ND-1:0] digit_sel;
  logic          frame_tick;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [ND-1:0] sel;
    logic [7:0]    seg;
    logic          ft;
  } exp_t;

  exp_t  sb_q[$];
  bit    sb_armed = 0;
  string sb_name  = "none";

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .bcd_in     (bcd_in),
    .error      (error),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: arm on frame start, then pop one entry per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!sb_armed && sb_q.size() > 0 && frame_tick === 1'b1) sb_armed = 1;
    if (sb_armed) begin
      e = sb_q.pop_front();
      total_cnt++;
      if (digit_sel !== e.sel || seg !== e.seg || frame_tick !== e.ft)
        $display("FAIL %s: got sel=%b seg=%h ft=%b, expected sel=%b seg=%h ft=%b",
                 sb_name, digit_sel, seg, frame_tick, e.sel, e.seg, e.ft);
      else
        pass_cnt++;
      if (sb_q.size() == 0) sb_armed = 0;
    end
  end

  // Queue one full frame: SD cycles per digit, tick on the first cycle.
  task automatic push_frame(input string name, input logic [7:0] d0, d1, d2, d3);
    logic [7:0] p [ND];
    exp_t e;
    p[0] = d0; p[1] = d1; p[2] = d2; p[3] = d3;
    sb_name = name;
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < SD; c++) begin
        e.sel = ND'(1) << d;
        e.seg = p[d];
        e.ft  = (d == 0 && c == 0);
        sb_q.push_back(e);
      end
  endtask

  // Wait for the monitor to consume the queue, within a cycle budget.
  task automatic drain(output bit ok);
    for (int i = 0; i < 80 && sb_q.size() > 0; i++) @(negedge clk);
    ok = (sb_q.size() == 0);
    if (!ok) begin sb_q.delete(); sb_armed = 0; end
  endtask

  // Capture a value; returns just after the first seg update using it.
  task automatic do_load(input logic [15:0] v, input logic e);
    @(negedge clk);
    load = 1'b1; bcd_in = v; error = e;
    @(negedge clk);
    load = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_reset;
    reset = 1'b1; load = 1'b0; error = 1'b0; bcd_in = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (seg !== 8'h00) $display("FAIL reset_seg: got %h expected 00", seg); else pass_cnt++;
    total_cnt++;
    if (digit_sel !== 4'b0000) $display("FAIL reset_sel: got %b expected 0000", digit_sel); else pass_cnt++;
    total_cnt++;
    if (frame_tick !== 1'b0) $display("FAIL reset_ft: got %b expected 0", frame_tick); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (digit_sel !== 4'b0001) $display("FAIL release_sel: got %b expected 0001", digit_sel); else pass_cnt++;
    total_cnt++;
    if (seg !== 8'h7E) $display("FAIL release_seg: got %h expected 7e", seg); else pass_cnt++;
  endtask

  task automatic test_scan;
    bit ok;
    int cnt;
    do_load(16'h1234, 1'b0);
    push_frame("scan_1234", 8'h33, 8'h79, 8'h6D, 8'h30);
    drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL scan_1234_timeout: queue not drained, expected empty"); else pass_cnt++;
    // Frame period: cycles from one tick to the next.
    cnt = 0;
    for (int i = 0; i < 40 && frame_tick !== 1'b1; i++) @(negedge clk);
    @(negedge clk); cnt = 1;
    while (frame_tick !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
    total_cnt++;
    if (cnt != ND*SD) $display("FAIL frame_period: got %0d expected %0d", cnt, ND*SD); else pass_cnt++;
  endtask

  task automatic test_lzb;
    bit ok;
    do_load(16'h0070, 1'b0);
`ifdef SEG7_LZB_EN
    push_frame("lzb_0070", 8'h7E, 8'h70, 8'h00, 8'h00);
`else
    push_frame("lzb_0070", 8'h7E, 8'h70, 8'h7E, 8'h7E);
`endif
    drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL lzb_timeout: queue not drained, expected empty"); else pass_cnt++;
  endtask

  task automatic test_error;
    bit ok;
    do_load(16'h1234, 1'b1);
    push_frame("error_on", 8'h00, 8'h05, 8'h05, 8'h4F);
    drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL error_on_timeout: queue not drained, expected empty"); else pass_cnt++;
    do_load(16'h0005, 1'b0);
`ifdef SEG7_LZB_EN
    push_frame("error_clear", 8'h5B, 8'h00, 8'h00, 8'h00);
`else
    push_frame("error_clear", 8'h5B, 8'h7E, 8'h7E, 8'h7E);
`endif
    drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL error_clear_timeout: queue not drained, expected empty"); else pass_cnt++;
  endtask

  task automatic test_hex;
    bit ok;
    do_load(16'hABCF, 1'b0);
    push_frame("hex_abcf", 8'h00, 8'h00, 8'h05, 8'h4F);
    drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL hex_timeout: queue not drained, expected empty"); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    bit ok;
    @(negedge clk);
    load = 1'b1; bcd_in = 16'h1111; error = 1'b0;
    @(negedge clk);
    bcd_in = 16'h5678;
    @(negedge clk);
    load = 1'b0; bcd_in = 16'hFFFF;  // must be ignored while load is low
    @(posedge clk); #2;
    push_frame("back_to_back", 8'h7F, 8'h70, 8'h5F, 8'h5B);
    drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL b2b_timeout: queue not drained, expected empty"); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    bit ok;
    int cnt;
    for (int i = 0; i < 40 && digit_sel !== 4'b0100; i++) @(negedge clk);
    total_cnt++;
    if (digit_sel !== 4'b0100) $display("FAIL mid_wait: got sel=%b expected 0100", digit_sel); else pass_cnt++;
    reset = 1'b1; load = 1'b1; bcd_in = 16'h9999; error = 1'b1;
    @(negedge clk);
    reset = 1'b0; load = 1'b0; error = 1'b0;
    total_cnt++;
    if (seg !== 8'h00 || digit_sel !== 4'b0000 || frame_tick !== 1'b0)
      $display("FAIL mid_reset_zero: got seg=%h sel=%b ft=%b expected 00/0000/0", seg, digit_sel, frame_tick);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (digit_sel !== 4'b0001 || seg !== 8'h7E)
      $display("FAIL mid_reset_restart: got sel=%b seg=%h expected 0001/7e", digit_sel, seg);
    else pass_cnt++;
    cnt = 1;
    @(negedge clk);
    while (digit_sel === 4'b0001 && cnt < 20) begin cnt++; @(negedge clk); end
    total_cnt++;
    if (cnt != SD) $display("FAIL mid_reset_slot: got %0d cycles expected %0d", cnt, SD); else pass_cnt++;
    // Shadow must be zero: the same-edge load was overridden by reset.
`ifdef SEG7_LZB_EN
    push_frame("mid_reset_shadow", 8'h7E, 8'h00, 8'h00, 8'h00);
`else
    push_frame("mid_reset_shadow", 8'h7E, 8'h7E, 8'h7E, 8'h7E);
`endif
    drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL mid_reset_timeout: queue not drained, expected empty"); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lzb();
    test_error();
    test_hex();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
